// File: rtl/md_sched.sv
// md_sched: issue controller and hazard scheduler for the HI/LO multiply-divide unit.
// Holds the MD op in EX, drives start/sel, mirrors the unit latency with a countdown,
// stalls MD instructions in ID that would touch an in-flight result, and produces
// HI/LO restore pulses when a completed mthi/mtlo in MEM is flushed by an interrupt.
module md_sched #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] id_md_op,
   input  logic       id_adv,
   input  logic       int_req,
   input  logic       int_victim_mem,
   input  logic       md_busy,
   output logic       md_start,
   output logic [2:0] md_sel,
   output logic       md_remthi,
   output logic       md_remtlo,
   output logic       md_stall,
   output logic [3:0] md_cnt
);

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFLO  = 4'd8;
   localparam logic [2:0] SEL_IDLE = 3'd7;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_LAT);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_LAT);

   typedef enum logic [1:0] {
      IDLE,
      MUL_RUN,
      DIV_RUN
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] exOp_q, exOp_d;
   logic       memMthi_q, memMthi_d;
   logic       memMtlo_q, memMtlo_d;
   logic [3:0] cnt_q, cnt_d;

   logic [3:0] idOp;
   logic       idIsMd;
   logic       exIsMulDiv;
   logic       exIsMul;
   logic [3:0] selRaw;
   logic [3:0] loadedVal;

   // Unit-facing outputs and the ID hazard check; codes 9..15 in ID behave as no MD op.
   always_comb begin
      idOp       = (id_md_op > OP_MFLO) ? OP_NONE : id_md_op;
      idIsMd     = (idOp != OP_NONE);
      exIsMulDiv = (exOp_q >= OP_MULT) && (exOp_q <= OP_DIVU);
      exIsMul    = (exOp_q == OP_MULT) || (exOp_q == OP_MULTU);
      selRaw     = exOp_q - 4'd1;
      md_start   = exIsMulDiv && !int_req;
      md_sel     = SEL_IDLE;
      if (!int_req && (exOp_q >= OP_MULT) && (exOp_q <= OP_MTLO)) begin
         md_sel = selRaw[2:0];
      end
      md_stall  = idIsMd && ((cnt_q != 4'd0) || md_start || md_busy);
      md_remthi = int_req && int_victim_mem && memMthi_q;
      md_remtlo = int_req && int_victim_mem && memMtlo_q;
      md_cnt    = cnt_q;
   end

   // Next-state: EX slot advance, MEM mthi/mtlo tracking, and the latency countdown with
   // its first-busy-cycle abort window.
   always_comb begin
      exOp_d    = (id_adv && !md_stall && !int_req) ? idOp : OP_NONE;
      memMthi_d = (exOp_q == OP_MTHI) && !int_req;
      memMtlo_d = (exOp_q == OP_MTLO) && !int_req;
      cnt_d     = cnt_q;
      state_d   = state_q;
      loadedVal = (state_q == MUL_RUN) ? MULT_LOAD : DIV_LOAD;
      if (md_start) begin
         if (exIsMul) begin
            cnt_d   = MULT_LOAD;
            state_d = MUL_RUN;
         end else begin
            cnt_d   = DIV_LOAD;
            state_d = DIV_RUN;
         end
      end else if (cnt_q != 4'd0) begin
         if (int_req && (cnt_q == loadedVal)) begin
            cnt_d = 4'd0;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
      end
      if (cnt_d == 4'd0) begin
         state_d = IDLE;
      end
   end

   // State registers; a synchronous reset clears any operation in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         exOp_q    <= OP_NONE;
         memMthi_q <= 1'b0;
         memMtlo_q <= 1'b0;
         cnt_q     <= 4'd0;
      end else begin
         state_q   <= state_d;
         exOp_q    <= exOp_d;
         memMthi_q <= memMthi_d;
         memMtlo_q <= memMtlo_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: vector table plus hand sequences for md_sched, with a small
// behavioural HI/LO unit model driven by the scheduler's start/sel/restore.
module tb_md_sched;

   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   logic       clk;
   logic       reset;
   logic [3:0] idMdOp;
   logic       idAdv;
   logic       intReq;
   logic       intVictimMem;
   logic       mdBusy;
   logic       mdStart;
   logic [2:0] mdSel;
   logic       mdRemthi;
   logic       mdRemtlo;
   logic       mdStall;
   logic [3:0] mdCnt;

   logic        forceBusy;
   logic [31:0] opA, opB;
   logic [31:0] hiM, loM, prevHiM, prevLoM;
   int          busyM, busyLoad;

   int checkCount;
   int passCount;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic        adv;
      logic        irq;
      logic        vic;
      logic [31:0] a;
      logic [31:0] b;
      logic        st;
      logic [2:0]  sel;
      logic        stall;
      logic        rh;
      logic        rl;
      logic [3:0]  cnt;
      logic        chkHi;
      logic [31:0] hi;
      logic        chkLo;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[$];
   vec_t sbQ[$];

   md_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk           (clk),
      .reset         (reset),
      .id_md_op      (idMdOp),
      .id_adv        (idAdv),
      .int_req       (intReq),
      .int_victim_mem(intVictimMem),
      .md_busy       (mdBusy),
      .md_start      (mdStart),
      .md_sel        (mdSel),
      .md_remthi     (mdRemthi),
      .md_remtlo     (mdRemtlo),
      .md_stall      (mdStall),
      .md_cnt        (mdCnt)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [63:0] mulS(input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sx, sy;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return 64'(sx * sy);
   endfunction

   assign mdBusy = (busyM != 0) || forceBusy;

   // Behavioural MD unit: results land at start, busy lasts the latency, mthi/mtlo keep
   // the old value so a restore pulse can put it back.
   always @(posedge clk) begin
      if (reset) begin
         hiM      <= 32'd0;
         loM      <= 32'd0;
         prevHiM  <= 32'd0;
         prevLoM  <= 32'd0;
         busyM    <= 0;
         busyLoad <= 0;
      end else if (mdStart) begin
         case (mdSel)
            3'd0: {hiM, loM} <= mulS(opA, opB);
            3'd1: {hiM, loM} <= {32'd0, opA} * {32'd0, opB};
            3'd2: if (opB != 32'd0) begin
                     loM <= 32'($signed(opA) / $signed(opB));
                     hiM <= 32'($signed(opA) % $signed(opB));
                  end
            3'd3: if (opB != 32'd0) begin
                     loM <= opA / opB;
                     hiM <= opA % opB;
                  end
            default: ;
         endcase
         busyM    <= (mdSel <= 3'd1) ? MULT_LAT : DIV_LAT;
         busyLoad <= (mdSel <= 3'd1) ? MULT_LAT : DIV_LAT;
      end else begin
         if (busyM != 0) busyM <= (intReq && busyM == busyLoad) ? 0 : busyM - 1;
         if (mdSel == 3'd4) begin
            prevHiM <= hiM;
            hiM     <= opA;
         end
         if (mdSel == 3'd5) begin
            prevLoM <= loM;
            loM     <= opA;
         end
         if (mdRemthi) hiM <= prevHiM;
         if (mdRemtlo) loM <= prevLoM;
      end
   end

   function automatic vec_t mk(input string n, input int op, input int adv, input int irq,
                               input int vic, input logic [31:0] a, input logic [31:0] b,
                               input int st, input int sel, input int stall, input int rh,
                               input int rl, input int cnt);
      vec_t v;
      v.name = n;     v.op = 4'(op);   v.adv = 1'(adv); v.irq = 1'(irq); v.vic = 1'(vic);
      v.a = a;        v.b = b;         v.st = 1'(st);   v.sel = 3'(sel); v.stall = 1'(stall);
      v.rh = 1'(rh);  v.rl = 1'(rl);   v.cnt = 4'(cnt);
      v.chkHi = 1'b0; v.hi = 32'd0;    v.chkLo = 1'b0;  v.lo = 32'd0;
      return v;
   endfunction

   task automatic addVec(input string n, input int op, input int adv, input int irq,
                         input int vic, input logic [31:0] a, input logic [31:0] b,
                         input int st, input int sel, input int stall, input int rh,
                         input int rl, input int cnt);
      vecs.push_back(mk(n, op, adv, irq, vic, a, b, st, sel, stall, rh, rl, cnt));
   endtask

   task automatic addHi(input logic [31:0] value);
      vec_t t;
      t = vecs.pop_back();
      t.chkHi = 1'b1;
      t.hi = value;
      vecs.push_back(t);
   endtask

   task automatic addLo(input logic [31:0] value);
      vec_t t;
      t = vecs.pop_back();
      t.chkLo = 1'b1;
      t.lo = value;
      vecs.push_back(t);
   endtask

   task automatic checkOutput(input string n, input string field, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s.%s got %0h want %0h", n, field, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      idMdOp       = v.op;
      idAdv        = v.adv;
      intReq       = v.irq;
      intVictimMem = v.vic;
      opA          = v.a;
      opB          = v.b;
   endtask

   // Drive one cycle, queue its expectation, compare at the falling edge, move past the rising edge.
   task automatic runVec(input vec_t v);
      vec_t e;
      applyStimulus(v);
      sbQ.push_back(v);
      @(negedge clk);
      e = sbQ.pop_front();
      checkOutput(e.name, "start", 32'(mdStart), 32'(e.st));
      checkOutput(e.name, "sel", 32'(mdSel), 32'(e.sel));
      checkOutput(e.name, "stall", 32'(mdStall), 32'(e.stall));
      checkOutput(e.name, "remthi", 32'(mdRemthi), 32'(e.rh));
      checkOutput(e.name, "remtlo", 32'(mdRemtlo), 32'(e.rl));
      checkOutput(e.name, "cnt", 32'(mdCnt), 32'(e.cnt));
      if (e.chkHi) checkOutput(e.name, "hi", hiM, e.hi);
      if (e.chkLo) checkOutput(e.name, "lo", loM, e.lo);
      @(posedge clk);
      #1;
   endtask

   // Safety timeout so the bench always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL timeout simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   // Main sequence.
   initial begin
      checkCount = 0;
      passCount  = 0;
      forceBusy  = 1'b0;
      reset      = 1'b1;
      applyStimulus(mk("init", 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0));

      // Reset and idle.
      addVec("idle", 0, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      // mult 0x7FFFFFFF*2 then mflo immediately.
      addVec("mul_id", 1, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      addVec("mul_issue", 8, 1, 0, 0, 32'h7FFF_FFFF, 2, 1, 0, 1, 0, 0, 0);
      for (int c = 5; c >= 1; c--) addVec("mul_busy", 8, 1, 0, 0, 0, 0, 0, 7, 1, 0, 0, c);
      addVec("mflo_go", 8, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      addVec("mflo_ex", 0, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      addHi(32'd0);
      addLo(32'hFFFF_FFFE);
      // divu 100/7, three adds, then mfhi.
      addVec("divu_id", 4, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      addVec("divu_issue", 0, 1, 0, 0, 100, 7, 1, 3, 0, 0, 0, 0);
      addVec("add_b", 0, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 10);
      addVec("add_c", 0, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 9);
      for (int c = 8; c >= 1; c--) addVec("mfhi_wait", 7, 1, 0, 0, 0, 0, 0, 7, 1, 0, 0, c);
      addVec("mfhi_go", 7, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      addVec("mfhi_ex", 0, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      addHi(32'd2);
      addLo(32'd14);
      // mult aborted in first busy cycle.
      addVec("mul2_id", 1, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      addVec("mul2_issue", 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      addVec("mul2_abort", 0, 1, 1, 0, 0, 0, 0, 7, 0, 0, 0, 5);
      addVec("mfhi_free", 7, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      addVec("mfhi_free_ex", 0, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      // mult with interrupt in third busy cycle keeps counting.
      addVec("mul3_id", 1, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      addVec("mul3_issue", 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      addVec("mul3_b1", 0, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 5);
      addVec("mul3_b2", 0, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 4);
      addVec("mul3_lateint", 0, 1, 1, 0, 0, 0, 0, 7, 0, 0, 0, 3);
      addVec("mul3_keep2", 7, 1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 2);
      addVec("mul3_keep1", 7, 1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 1);
      addVec("mul3_done", 7, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      addVec("mul3_ex", 0, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      // mthi 0xAAAA, mthi 0x1234, then restore while the second is in MEM.
      addVec("mthi_id", 5, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      addVec("mthi_a", 5, 1, 0, 0, 32'hAAAA, 0, 0, 4, 0, 0, 0, 0);
      addVec("mthi_b", 7, 1, 0, 0, 32'h1234, 0, 0, 4, 0, 0, 0, 0);
      addHi(32'hAAAA);
      addVec("mthi_restore", 0, 1, 1, 1, 0, 0, 0, 7, 0, 1, 0, 0);
      addHi(32'h1234);
      addVec("mthi_after", 0, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      addHi(32'hAAAA);
      // Interrupt without MEM victim: no restore.
      addVec("mthi2_id", 5, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      addVec("mthi2_ex", 0, 1, 0, 0, 32'h5555, 0, 0, 4, 0, 0, 0, 0);
      addVec("norestore", 0, 1, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      addVec("norestore_after", 0, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      addHi(32'h5555);
      // mtlo restore.
      addVec("mtlo_id", 6, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      addVec("mtlo_ex", 0, 1, 0, 0, 32'h77, 0, 0, 5, 0, 0, 0, 0);
      addVec("mtlo_restore", 0, 1, 1, 1, 0, 0, 0, 7, 0, 0, 1, 0);
      addVec("mtlo_after", 0, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      addLo(32'd0);
      // mthi flushed while in EX never reaches MEM and never writes.
      addVec("mthi_fl_id", 5, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      addVec("mthi_flush", 0, 1, 1, 0, 32'h9999, 0, 0, 7, 0, 0, 0, 0);
      addVec("mthi_fl_mem", 0, 1, 1, 1, 0, 0, 0, 7, 0, 0, 0, 0);
      addHi(32'h5555);
      // Interrupt with div in EX.
      addVec("div_id", 3, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      addVec("div_int", 0, 1, 1, 0, 50, 5, 0, 7, 0, 0, 0, 0);
      addVec("div_int_after", 0, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      // No advance: op never reaches EX.
      addVec("noadv", 1, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      addVec("noadv_after", 0, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      foreach (vecs[i]) runVec(vecs[i]);

      // Unit busy alone stalls MD ops but not codes 9..15.
      forceBusy = 1'b1;
      runVec(mk("busy_badop", 12, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0));
      runVec(mk("busy_mfhi", 7, 1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0));
      forceBusy = 1'b0;
      runVec(mk("busy_clear", 0, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0));

      // Reset in the middle of a multiply.
      runVec(mk("rst_mul_id", 1, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0));
      runVec(mk("rst_mul_issue", 0, 1, 0, 0, 3, 3, 1, 0, 0, 0, 0, 0));
      runVec(mk("rst_mul_busy", 0, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 5));
      reset = 1'b1;
      runVec(mk("rst_cycle", 0, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 4));
      reset = 1'b0;
      runVec(mk("rst_after", 7, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0));
      runVec(mk("rst_idle", 0, 1, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0));

      if (sbQ.size() != 0) begin
         checkCount++;
         $display("[TB] FAIL scoreboard leftover got %0d want 0", sbQ.size());
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
